// File: rtl/mesh_router_xy.sv
// mesh_router_xy: 5-port (S,W,N,E,C) XY dimension-order mesh router with per-input FIFOs,
// round-robin output arbitration and registered outputs. MESH_ROUTER_ERR_EN drops U-turn flits.
module mesh_router_xy #(
  parameter int X          = 0,
  parameter int Y          = 0,
  parameter int COORD_W    = 4,
  parameter int FLIT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_ready,
  input  logic [5*FLIT_W-1:0] in_data,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_ready,
  output logic [5*FLIT_W-1:0] out_data
`ifdef MESH_ROUTER_ERR_EN
  ,
  output logic [4:0]          route_err
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [COORD_W-1:0] XC = COORD_W'(X);
  localparam logic [COORD_W-1:0] YC = COORD_W'(Y);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [FLIT_W-1:0] mem [5][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr [5];
  logic [AW-1:0]     rd_ptr [5];
  logic [CW-1:0]     count [5];
  logic [FLIT_W-1:0] head [5];
  logic [2:0]        route [5];
  logic [4:0]        push, pop, head_valid, drop;
  logic [4:0]        req [5];
  logic [4:0]        slot_free, gnt_valid;
  logic [2:0]        gnt_idx [5];
  logic [FLIT_W-1:0] gnt_data [5];
  logic [2:0]        rr_ptr [5];

  // Head decode: in_ready depends only on registered count.
  always_comb begin
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = '0;
    dy = '0;
    for (int unsigned p = 0; p < 5; p++) begin
      in_ready[p]   = (count[p] != FULL);
      push[p]       = in_valid[p] & in_ready[p];
      head_valid[p] = (count[p] != '0);
      head[p]       = mem[p][rd_ptr[p]];
      dx            = head[p][FLIT_W-1 -: COORD_W];
      dy            = head[p][FLIT_W-1-COORD_W -: COORD_W];
      if (dx > XC)      route[p] = 3'd3;
      else if (dx < XC) route[p] = 3'd1;
      else if (dy > YC) route[p] = 3'd2;
      else if (dy < YC) route[p] = 3'd0;
      else              route[p] = 3'd4;
`ifdef MESH_ROUTER_ERR_EN
      drop[p] = head_valid[p] && (p < 4) && (route[p] == 3'(p));
`else
      drop[p] = 1'b0;
`endif
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < 5; o++) begin
      req[o] = '0;
      for (int unsigned p = 0; p < 5; p++)
        req[o][p] = head_valid[p] & ~drop[p] & (route[p] == 3'(o));
    end
  end

  // Round-robin search starting at rr_ptr, only when the output slot can take a flit.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    sum = '0;
    idx = '0;
    for (int unsigned o = 0; o < 5; o++) begin
      slot_free[o] = ~out_valid[o] | out_ready[o];
      gnt_valid[o] = 1'b0;
      gnt_idx[o]   = '0;
      gnt_data[o]  = '0;
      for (int unsigned k = 0; k < 5; k++) begin
        sum = {1'b0, rr_ptr[o]} + 4'(k);
        if (sum >= 4'd5) sum = sum - 4'd5;
        idx = sum[2:0];
        if (slot_free[o] && !gnt_valid[o] && req[o][idx]) begin
          gnt_valid[o] = 1'b1;
          gnt_idx[o]   = idx;
          gnt_data[o]  = head[idx];
        end
      end
    end
  end

  always_comb begin
    pop = drop;
    for (int unsigned o = 0; o < 5; o++)
      if (gnt_valid[o]) pop[gnt_idx[o]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < 5; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < 5; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
        count[p] <= count[p] + CW'(push[p]) - CW'(pop[p]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 5; p++)
      if (push[p]) mem[p][wr_ptr[p]] <= in_data[p*FLIT_W +: FLIT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      for (int unsigned o = 0; o < 5; o++) rr_ptr[o] <= '0;
    end else begin
      for (int unsigned o = 0; o < 5; o++) begin
        if (gnt_valid[o]) begin
          out_valid[o]                  <= 1'b1;
          out_data[o*FLIT_W +: FLIT_W]  <= gnt_data[o];
          rr_ptr[o] <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
        end else if (slot_free[o]) begin
          out_valid[o] <= 1'b0;
        end
      end
    end
  end

`ifdef MESH_ROUTER_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) route_err <= '0;
    else        route_err <= route_err | drop;
  end
`endif

endmodule
